// File: rtl/keypad_pkg.sv
// Shared constants for the 4x4 keypad scanner: FSM encoding, special key
// codes and the {row,col} -> hex key map.
package keypad_pkg;

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_PRESSED  = 2'd2;

    typedef enum logic [1:0] {
        SCAN     = ST_SCAN,
        DEBOUNCE = ST_DEBOUNCE,
        PRESSED  = ST_PRESSED
    } state_t;

    localparam logic [3:0] KEY_BLANK = 4'hF;
    localparam logic [3:0] KEY_CLEAR = 4'hE;
    localparam logic [3:0] KEY_BACK  = 4'hF;

    // Indexed by {row[1:0], col[1:0]}; highest index listed first.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hF, 4'h0, 4'hE,   // row 3: *  0  #  D
        4'hC, 4'h9, 4'h8, 4'h7,   // row 2: 7  8  9  C
        4'hB, 4'h6, 4'h5, 4'h4,   // row 1: 4  5  6  B
        4'hA, 4'h3, 4'h2, 4'h1    // row 0: 1  2  3  A
    };

endpackage

// File: rtl/keypad_debounce_cnt.sv
// Column dwell tick generator and saturating match counter used by the
// keypad scanner FSM to debounce presses and releases.
module keypad_debounce_cnt #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic cnt_clr,
    input  logic cnt_inc,
    output logic tick,
    output logic cnt_last
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] deb_cnt;

    assign tick = (div_cnt == DIV_W'(SCAN_DIV - 1));

    // One more matching tick would reach the threshold; lets the FSM act on
    // the threshold in the same tick without a combinational loop.
    assign cnt_last = (deb_cnt >= CNT_W'(DEBOUNCE_SCANS - 1));

    // Free-running dwell counter, wraps at SCAN_DIV-1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Match counter: clear wins over increment, saturates at the threshold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb_cnt <= '0;
        end else if (cnt_clr) begin
            deb_cnt <= '0;
        end else if (cnt_inc && (deb_cnt != CNT_W'(DEBOUNCE_SCANS))) begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/keypad_4x4_scanner.sv
// 4x4 matrix keypad scanner with press/release debouncing.
// Optional feature macro: KEYPAD_DIGIT_BUF_EN enables the five-digit BCD
// entry buffer on digit_0..digit_4; otherwise those outputs are tied blank.
module keypad_4x4_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [3:0] digit_0,
    output logic [3:0] digit_1,
    output logic [3:0] digit_2,
    output logic [3:0] digit_3,
    output logic [3:0] digit_4
);

    logic [3:0] rows_p0, rows_s;
    logic [1:0] row_sel, lat_row, lat_row_nxt;
    logic [1:0] col_idx, col_idx_nxt;
    logic [3:0] acc_idx;
    logic       tick, cnt_last, cnt_clr, cnt_inc;
    logic       accept, release_done, any_low, lat_low;
    state_t     state, state_nxt;

    keypad_debounce_cnt #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_deb (
        .clk     (clk),
        .reset   (reset),
        .cnt_clr (cnt_clr),
        .cnt_inc (cnt_inc),
        .tick    (tick),
        .cnt_last(cnt_last)
    );

    // Two-flop synchronizer for the asynchronous row lines (idle high).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rows_p0 <= 4'hF;
            rows_s  <= 4'hF;
        end else begin
            // stage p0 -> s
            rows_p0 <= row_in;
            rows_s  <= rows_p0;
        end
    end

    assign any_low = (rows_s != 4'hF);
    assign lat_low = ~rows_s[lat_row];

    // Lowest-numbered active row wins.
    always_comb begin
        if (!rows_s[0])      row_sel = 2'd0;
        else if (!rows_s[1]) row_sel = 2'd1;
        else if (!rows_s[2]) row_sel = 2'd2;
        else                 row_sel = 2'd3;
    end

    // Next-state logic; everything advances only on the dwell tick.
    always_comb begin
        state_nxt    = state;
        col_idx_nxt  = col_idx;
        lat_row_nxt  = lat_row;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        accept       = 1'b0;
        release_done = 1'b0;
        acc_idx      = {lat_row, col_idx};
        if (tick) begin
            case (state)
                SCAN: begin
                    if (any_low) begin
                        lat_row_nxt = row_sel;
                        acc_idx     = {row_sel, col_idx};
                        cnt_inc     = 1'b1;
                        if (cnt_last) begin
                            // Single-scan debounce accepts on the detecting tick.
                            accept    = 1'b1;
                            cnt_clr   = 1'b1;
                            state_nxt = PRESSED;
                        end else begin
                            state_nxt = DEBOUNCE;
                        end
                    end else begin
                        col_idx_nxt = col_idx + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (lat_low) begin
                        cnt_inc = 1'b1;
                        if (cnt_last) begin
                            accept    = 1'b1;
                            cnt_clr   = 1'b1;
                            state_nxt = PRESSED;
                        end
                    end else begin
                        cnt_clr     = 1'b1;
                        state_nxt   = SCAN;
                        col_idx_nxt = col_idx + 2'd1;
                    end
                end
                PRESSED: begin
                    if (!lat_low) begin
                        cnt_inc = 1'b1;
                        if (cnt_last) begin
                            cnt_clr      = 1'b1;
                            release_done = 1'b1;
                            state_nxt    = SCAN;
                            col_idx_nxt  = col_idx + 2'd1;
                        end
                    end else begin
                        cnt_clr = 1'b1;
                    end
                end
                default: begin
                    cnt_clr   = 1'b1;
                    state_nxt = SCAN;
                end
            endcase
        end
    end

    // FSM, column drive and key outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            lat_row   <= 2'd0;
            col_out   <= 4'b1111;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_nxt;
            col_idx   <= col_idx_nxt;
            lat_row   <= lat_row_nxt;
            col_out   <= ~(4'b0001 << col_idx_nxt);
            key_valid <= accept;
            if (accept) begin
                key_code <= KEY_MAP[acc_idx];
                key_held <= 1'b1;
            end else if (release_done) begin
                key_held <= 1'b0;
            end
        end
    end

`ifdef KEYPAD_DIGIT_BUF_EN
    logic [4:0][3:0] dig;

    // Entry buffer: digits shift in from the right, * clears, # backspaces.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dig <= {5{KEY_BLANK}};
        end else if (key_valid) begin
            if (key_code <= 4'h9) begin
                dig <= {dig[3:0], key_code};
            end else if (key_code == KEY_CLEAR) begin
                dig <= {5{KEY_BLANK}};
            end else if (key_code == KEY_BACK) begin
                dig <= {KEY_BLANK, dig[4:1]};
            end
        end
    end

    assign digit_0 = dig[0];
    assign digit_1 = dig[1];
    assign digit_2 = dig[2];
    assign digit_3 = dig[3];
    assign digit_4 = dig[4];
`else
    assign digit_0 = KEY_BLANK;
    assign digit_1 = KEY_BLANK;
    assign digit_2 = KEY_BLANK;
    assign digit_3 = KEY_BLANK;
    assign digit_4 = KEY_BLANK;
`endif

endmodule

// File: tb/tb_keypad_4x4_scanner.sv
// Self-checking bench for keypad_4x4_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=3).
module tb_keypad_4x4_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  row_in;
    logic [3:0]  col_out, key_code;
    logic        key_valid, key_held;
    logic [3:0]  digit_0, digit_1, digit_2, digit_3, digit_4;

    logic        use_model = 1'b1;
    logic [15:0] pressed = 16'h0;
    logic [3:0]  row_force = 4'hF;
    logic [3:0]  model_rows;

    int checks = 0;
    int failures = 0;
    int vld_count = 0;

    typedef struct {
        int         row;
        int         col;
        logic [3:0] code;
    } vec_t;
    vec_t tbl[16];

    keypad_4x4_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .clk(clk), .reset(reset), .row_in(row_in), .col_out(col_out),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held),
        .digit_0(digit_0), .digit_1(digit_1), .digit_2(digit_2),
        .digit_3(digit_3), .digit_4(digit_4)
    );

    always #5 clk = ~clk;

    // Passive keypad: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        model_rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_out[c]) model_rows[r] = 1'b0;
    end
    assign row_in = use_model ? model_rows : row_force;

    always @(negedge clk) if (reset && key_valid) vld_count++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (key_valid) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_release(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (!key_held) begin ok = 1'b1; break; end
        end
    endtask

    // Waits for the start of a fresh dwell on the requested column.
    task automatic wait_col(input logic [3:0] target, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (col_out != target) break;
        end
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (col_out == target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic press_key(input int r, input int c, input logic [3:0] code, input bit do_check);
        bit ok;
        use_model = 1'b1;
        pressed = 16'h0;
        pressed[r*4+c] = 1'b1;
        wait_valid(60, ok);
        if (do_check) begin
            check($sformatf("key_r%0dc%0d_valid", r, c), {31'd0, ok}, 32'd1);
            check($sformatf("key_r%0dc%0d_code", r, c), {28'd0, key_code}, {28'd0, code});
            check($sformatf("key_r%0dc%0d_held", r, c), {31'd0, key_held}, 32'd1);
            check($sformatf("key_r%0dc%0d_col", r, c), {28'd0, col_out}, {28'd0, ~(4'b0001 << c)});
        end
        pressed = 16'h0;
        wait_release(60, ok);
        if (do_check) begin
            check($sformatf("key_r%0dc%0d_release", r, c), {31'd0, ok}, 32'd1);
            check($sformatf("key_r%0dc%0d_resume", r, c), {28'd0, col_out},
                  {28'd0, ~(4'b0001 << ((c + 1) % 4))});
        end
    endtask

    task automatic check_digits(input string name, input logic [19:0] exp);
        check(name, {12'd0, digit_4, digit_3, digit_2, digit_1, digit_0}, {12'd0, exp});
    endtask

    initial begin
        bit ok;
        int v0;
        logic [3:0] seq[5];

        tbl[0]  = '{0, 0, 4'h1}; tbl[1]  = '{0, 1, 4'h2}; tbl[2]  = '{0, 2, 4'h3}; tbl[3]  = '{0, 3, 4'hA};
        tbl[4]  = '{1, 0, 4'h4}; tbl[5]  = '{1, 1, 4'h5}; tbl[6]  = '{1, 2, 4'h6}; tbl[7]  = '{1, 3, 4'hB};
        tbl[8]  = '{2, 0, 4'h7}; tbl[9]  = '{2, 1, 4'h8}; tbl[10] = '{2, 2, 4'h9}; tbl[11] = '{2, 3, 4'hC};
        tbl[12] = '{3, 0, 4'hE}; tbl[13] = '{3, 1, 4'h0}; tbl[14] = '{3, 2, 4'hF}; tbl[15] = '{3, 3, 4'hD};

        // Reset state and idle scan sequence
        repeat (3) @(negedge clk);
        check("rst_col", {28'd0, col_out}, 32'hF);
        check("rst_code", {28'd0, key_code}, 32'h0);
        check("rst_valid", {31'd0, key_valid}, 32'd0);
        check("rst_held", {31'd0, key_held}, 32'd0);
        check_digits("rst_digits", 20'hFFFFF);
        reset = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check($sformatf("idle_col_k%0d", k), {28'd0, col_out},
                  {28'd0, ~(4'b0001 << ((k / 4) % 4))});
        end
        check("idle_no_valid", vld_count, 0);

        // Key 6 held on column 2: one pulse, frozen column, release resumes on column 3
        v0 = vld_count;
        pressed = 16'h0;
        pressed[1*4+2] = 1'b1;
        wait_valid(60, ok);
        check("k6_valid", {31'd0, ok}, 32'd1);
        check("k6_code", {28'd0, key_code}, 32'h6);
        check("k6_held", {31'd0, key_held}, 32'd1);
        check("k6_col", {28'd0, col_out}, 32'hB);
        repeat (20) @(negedge clk);
        check("k6_frozen", {28'd0, col_out}, 32'hB);
        check("k6_single_pulse", vld_count - v0, 1);
        pressed = 16'h0;
        wait_release(60, ok);
        check("k6_release", {31'd0, ok}, 32'd1);
        check("k6_resume_col", {28'd0, col_out}, 32'h7);

        // One-tick bounce on row0/col0 is rejected
        use_model = 1'b0;
        row_force = 4'hF;
        v0 = vld_count;
        wait_col(4'hE, 40, ok);
        check("bounce_sync", {31'd0, ok}, 32'd1);
        row_force = 4'b1110;
        repeat (4) @(negedge clk);
        row_force = 4'hF;
        repeat (4) @(negedge clk);
        check("bounce_col", {28'd0, col_out}, 32'hD);
        repeat (4) @(negedge clk);
        check("bounce_scan", {28'd0, col_out}, 32'hB);
        check("bounce_no_valid", vld_count - v0, 0);

        // Rows 1 and 3 together on col0, then a bouncy release
        v0 = vld_count;
        wait_col(4'hE, 40, ok);
        check("multi_sync", {31'd0, ok}, 32'd1);
        row_force = 4'b0101;
        wait_valid(30, ok);
        check("multi_valid", {31'd0, ok}, 32'd1);
        check("multi_code", {28'd0, key_code}, 32'h4);
        seq[0] = 4'hF; seq[1] = 4'b0101; seq[2] = 4'hF; seq[3] = 4'hF; seq[4] = 4'hF;
        for (int i = 0; i < 5; i++) begin
            row_force = seq[i];
            repeat (4) @(negedge clk);
            check($sformatf("multi_held_t%0d", i), {31'd0, key_held}, (i < 4) ? 32'd1 : 32'd0);
        end
        check("multi_resume_col", {28'd0, col_out}, 32'hD);
        check("multi_single_pulse", vld_count - v0, 1);

        // Every key through the keypad model
        for (int i = 0; i < 16; i++) press_key(tbl[i].row, tbl[i].col, tbl[i].code, 1'b1);

        // Digit entry buffer
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        press_key(0, 0, 4'h1, 1'b0);
        press_key(0, 1, 4'h2, 1'b0);
        press_key(0, 2, 4'h3, 1'b0);
`ifdef KEYPAD_DIGIT_BUF_EN
        check_digits("buf_123", 20'hFF123);
`else
        check_digits("buf_123", 20'hFFFFF);
`endif
        press_key(3, 2, 4'hF, 1'b0);
`ifdef KEYPAD_DIGIT_BUF_EN
        check_digits("buf_back", 20'hFFF12);
`else
        check_digits("buf_back", 20'hFFFFF);
`endif
        press_key(0, 3, 4'hA, 1'b0);
        press_key(3, 3, 4'hD, 1'b0);
`ifdef KEYPAD_DIGIT_BUF_EN
        check_digits("buf_letters", 20'hFFF12);
`else
        check_digits("buf_letters", 20'hFFFFF);
`endif
        press_key(3, 0, 4'hE, 1'b0);
        check("buf_last_code", {28'd0, key_code}, 32'hE);
        check_digits("buf_clear", 20'hFFFFF);

        // Reset in the middle of a debounce
        use_model = 1'b0;
        row_force = 4'hF;
        v0 = vld_count;
        wait_col(4'hE, 40, ok);
        check("midrst_sync", {31'd0, ok}, 32'd1);
        row_force = 4'b1110;
        repeat (8) @(negedge clk);
        check("midrst_deb_cnt", {30'd0, dut.u_deb.deb_cnt}, 32'd2);
        reset = 1'b0;
        #1;
        check("midrst_col", {28'd0, col_out}, 32'hF);
        check("midrst_code", {28'd0, key_code}, 32'h0);
        check("midrst_valid", {31'd0, key_valid}, 32'd0);
        check("midrst_held", {31'd0, key_held}, 32'd0);
        check_digits("midrst_digits", 20'hFFFFF);
        repeat (3) @(negedge clk);
        row_force = 4'hF;
        reset = 1'b1;
        repeat (30) @(negedge clk);
        check("midrst_no_valid", vld_count - v0, 0);
        check("midrst_scan_col", {28'd0, col_out}, 32'h7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
